// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency line memory answering cache fill/write-back requests
// Holds full lines in an internal array; one-cycle mem_ready pulse per accepted request.

module line_memory_responder #(
    parameter int LATENCY    = 8,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic                  op_write_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ready_q;
    logic [LINE_W-1:0]     rdata_q;
    logic                  perr_q;

    logic [LINE_W-1:0] mem_q [0:DEPTH-1];

    logic req_match_d;
    logic commit_d;
    logic unused_upper_addr;

    // Upper address bits alias onto the same lines.
    assign unused_upper_addr = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    // A write accepted with both strobes high stays matched while mem_write holds.
    assign req_match_d = op_write_q ? mem_write : (mem_read && !mem_write);
    assign commit_d    = (state_q == BUSY) && req_match_d && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (commit_d && op_write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (mem_read || mem_write) begin
                        op_write_q <= mem_write;
                        idx_q      <= mem_addr[DEPTH_LOG2-1:0];
                        wdata_q    <= mem_wdata;
                        cnt_q      <= CNT_LOAD;
                        state_q    <= BUSY;
                        if (mem_read && mem_write) begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!req_match_d) begin
                        perr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= RESP;
                        if (!op_write_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end
                end
                RESP: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign proto_err = perr_q;

endmodule
